fixedfloat_sched: RTL and testbench
===================================

Name: fixedfloat_sched

Overview:
- Round-robin scheduler that shares one fixedfloat converter among NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the converter's targetnumber/fixpointpos/opcode from registered operands.
- Waits CONV_LATENCY cycles, captures the converter result, and returns it tagged with the requester index.
- Sits between the requesting units and the single converter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); IDW = clog2(NUM_REQ).
- CONV_LATENCY, 1, cycles from converter operand change to valid result (1..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_number  in  32*NUM_REQ  flattened operands; requester i uses bits [32i+31:32i].
- req_pos  in  5*NUM_REQ  flattened fixpointpos per requester.
- req_opcode  in  NUM_REQ  conversion opcode per requester (0 = fixed->float, 1 = float->fixed).
- req_ready  out  NUM_REQ  one-hot accept strobe.
- conv_number  out  32  to converter targetnumber.
- conv_pos  out  5  to converter fixpointpos.
- conv_opcode  out  1  to converter opcode.
- conv_result  in  32  from converter result.
- resp_valid  out  1  response available.
- resp_id  out  IDW  index of the requester owning the response.
- resp_data  out  32  converted value.
- resp_ready  in  1  consumer accepts the response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, wait counter=0.
  - conv_number=0, conv_pos=0, conv_opcode=0.
  - resp_valid=0, resp_id=0, resp_data=0, busy=0, req_ready=0.
- Reset mid-operation: the in-flight operation is dropped; no response is issued after reset releases.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Grant goes to the first asserted req_valid bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
  - req_ready[g] is combinational, asserted only in IDLE, and only for the granted index.
  - On accept, the block registers req_number/pos/opcode of g onto conv_* and stores g.
  - On accept: rr_ptr <= (g+1) mod NUM_REQ, counter <= CONV_LATENCY, next state WAIT.
- WAIT:
  - conv_* held stable.
  - Counter decrements each cycle.
  - When counter==1: resp_data <= conv_result, resp_id <= g, resp_valid <= 1, next state DONE.
- DONE:
  - resp_valid/resp_id/resp_data held stable until resp_ready=1.
  - On resp_ready=1: resp_valid <= 0, next state IDLE.
  - New requests are not accepted in DONE.
- Latency: accept edge to resp_valid high = CONV_LATENCY+1 clocks. Minimum issue interval = CONV_LATENCY+2 clocks with resp_ready tied high.
- req_valid deasserting while not granted is legal; nothing is latched.
- rr_ptr advances only on accept. A single active requester is granted every slot.
- conv_* retain the last operands while idle; no zeroing.

Optional Feature:
- Macro: FXFL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a granted request whose 32-bit operand is 0x00000000 skips WAIT.
  - resp_data <= 0 and resp_valid <= 1 on the accept edge; state goes directly to DONE (latency 1 clock).
  - conv_* are not updated for bypassed requests.
  - rr_ptr advances as normal.
- Not defined: zero operands go through the converter like any other value.

Test Plan:
- Reset then single request:
  - Stimulus: rst low 2 cycles; requester 0 with number=0x32800000, pos=25, opcode=0; stub converter returns 0x41CA0000 after 1 cycle.
  - Required: req_ready[0] pulses once; resp_valid rises 2 clocks after accept; resp_id=0; resp_data=0x41CA0000.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, resp_ready=1.
  - Required: grant order 0,1,2,3,0; each accept exactly CONV_LATENCY+2 clocks apart.
- Pointer wrap:
  - Stimulus: only requesters 3 and 1 active; rr_ptr=2.
  - Required: grants 3 then 1 then 3.
- Response backpressure:
  - Stimulus: resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_valid/resp_id/resp_data stable; req_ready all 0; busy=1; completes the cycle after resp_ready=1.
- Reset during WAIT:
  - Stimulus: rst low one cycle mid-WAIT.
  - Required: resp_valid=0 immediately; busy=0; no response afterward; next grant from requester 0.
- Zero bypass with FXFL_ZERO_BYPASS_EN defined:
  - Stimulus: number=0 on requester 2.
  - Required: resp_valid 1 clock after accept; resp_data=0; resp_id=2; conv_number unchanged.
  - Without the macro: latency is CONV_LATENCY+1.

Source files
------------

// File: rtl/fixedfloat_sched.sv
// fixedfloat_sched: round-robin scheduler sharing one fixedfloat converter among NUM_REQ requesters.
// Optional zero-operand bypass enabled by defining FXFL_ZERO_BYPASS_EN.
module fixedfloat_sched #(
  parameter int NUM_REQ = 4,
  parameter int CONV_LATENCY = 1,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_number,
  input  logic [5*NUM_REQ-1:0]   req_pos,
  input  logic [NUM_REQ-1:0]     req_opcode,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            conv_number,
  output logic [4:0]             conv_pos,
  output logic                   conv_opcode,
  input  logic [31:0]            conv_result,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [31:0]            resp_data,
  input  logic                   resp_ready,
  output logic                   busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [IDW-1:0] rr_ptr, cur, gnt;
  logic [2:0] cnt;
  logic hit, acc, byp;
  logic [31:0] sel_num;
  function automatic logic [IDW-1:0] wrap(input logic [IDW:0] v);
    return v >= (IDW+1)'(NUM_REQ) ? IDW'(v - (IDW+1)'(NUM_REQ)) : IDW'(v);
  endfunction
  // Scanning downward and overwriting leaves the first hit at or after rr_ptr.
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (req_valid[wrap({1'b0, rr_ptr} + (IDW+1)'(k))]) begin
        gnt = wrap({1'b0, rr_ptr} + (IDW+1)'(k));
        hit = 1'b1;
      end
  end
  assign acc = rst && state == IDLE && hit;
  assign req_ready = acc ? NUM_REQ'(1) << gnt : '0;
  assign sel_num = req_number[32*gnt +: 32];
  assign busy = state != IDLE;
`ifdef FXFL_ZERO_BYPASS_EN
  assign byp = sel_num == '0;
`else
  assign byp = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      cur <= '0;
      cnt <= '0;
      conv_number <= '0;
      conv_pos <= '0;
      conv_opcode <= 1'b0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
    end else
      case (state)
        IDLE: if (acc) begin
          rr_ptr <= wrap({1'b0, gnt} + 1'b1);
          cur <= gnt;
          if (byp) begin
            resp_data <= '0;
            resp_id <= gnt;
            resp_valid <= 1'b1;
            state <= DONE;
          end else begin
            conv_number <= sel_num;
            conv_pos <= req_pos[5*gnt +: 5];
            conv_opcode <= req_opcode[gnt];
            cnt <= 3'(CONV_LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == 3'd1) begin
            resp_data <= conv_result;
            resp_id <= cur;
            resp_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fixedfloat_sched.sv
// tb_fixedfloat_sched: directed table-driven bench for fixedfloat_sched with a combinational converter stub.
module tb_fixedfloat_sched;
  localparam int L = 1;
  logic clk = 1'b0, rst = 1'b0, resp_ready = 1'b1;
  logic [3:0] req_valid = '0, req_ready, req_opcode;
  logic [127:0] req_number;
  logic [19:0] req_pos;
  logic [31:0] conv_number, conv_result, resp_data;
  logic [4:0] conv_pos;
  logic conv_opcode, resp_valid, busy;
  logic [1:0] resp_id;
  logic [31:0] num [4] = '{32'h32800000, 32'h12345678, 32'hDEADBEEF, 32'h0000FFFF};
  logic [4:0] pos [4] = '{5'd25, 5'd3, 5'd17, 5'd0};
  logic op [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int cyc = 0, n_chk = 0, n_fail = 0, last_acc = 0;
  typedef struct { logic [3:0] mask; int g; bit gap; logic [31:0] data; } vec_t;
  vec_t tbl [11];
  function automatic logic [31:0] stub(input logic [31:0] n, input logic [4:0] p, input logic o);
    return (n == 32'h32800000 && p == 5'd25 && !o) ? 32'h41CA0000 : {n[15:0], n[31:16]} ^ {27'b0, p} ^ {31'b0, o};
  endfunction
  assign req_number = {num[3], num[2], num[1], num[0]};
  assign req_pos = {pos[3], pos[2], pos[1], pos[0]};
  assign req_opcode = {op[3], op[2], op[1], op[0]};
  assign conv_result = stub(conv_number, conv_pos, conv_opcode);
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fixedfloat_sched #(.NUM_REQ(4), .CONV_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_number(req_number), .req_pos(req_pos),
    .req_opcode(req_opcode), .req_ready(req_ready), .conv_number(conv_number), .conv_pos(conv_pos),
    .conv_opcode(conv_opcode), .conv_result(conv_result), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_ready(resp_ready), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic slot(input logic [3:0] mask, input int eg, input bit gap, input int lat, input logic [31:0] ed);
    int n, c;
    req_valid = mask;
    #1;
    n = 0;
    while (req_ready == '0 && n < 20) begin @(negedge clk); #1; n++; end
    chk("grant", {28'b0, req_ready}, 32'(4'b1 << eg));
    if (gap) chk("issue_gap", cyc - last_acc, L + 2);
    c = cyc;
    last_acc = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
    chk("latency", cyc - c, lat);
    chk("resp_id", {30'b0, resp_id}, eg);
    chk("resp_data", resp_data, ed);
  endtask
  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{4'b1111, i % 4, i > 0, stub(num[i%4], pos[i%4], op[i%4])};
    tbl[5] = '{4'b0010, 1, 1, stub(num[1], pos[1], op[1])};
    tbl[6] = '{4'b1010, 3, 1, stub(num[3], pos[3], op[3])};
    tbl[7] = '{4'b1010, 1, 1, stub(num[1], pos[1], op[1])};
    tbl[8] = '{4'b1010, 3, 1, stub(num[3], pos[3], op[3])};
    tbl[9] = '{4'b0100, 2, 1, stub(num[2], pos[2], op[2])};
    tbl[10] = '{4'b0100, 2, 1, stub(num[2], pos[2], op[2])};
    repeat (2) @(negedge clk);
    chk("rst_outputs", {resp_valid, busy, resp_id, req_ready}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_conv", {conv_number ^ {27'b0, conv_pos}, 31'b0, conv_opcode}, 0);
    rst = 1'b1;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", {28'b0, req_ready}, 1);
    last_acc = cyc;
    @(negedge clk);
    req_valid = '0;
    chk("t1_wait", {28'b0, req_ready, busy, resp_valid}, 4'b0010);
    chk("t1_conv_number", conv_number, 32'h32800000);
    @(negedge clk);
    chk("t1_latency", cyc - last_acc, 2);
    chk("t1_resp", {resp_valid, 29'b0, resp_id}, 32'h80000000);
    chk("t1_data", resp_data, 32'h41CA0000);
    @(negedge clk);
    chk("t1_idle", {30'b0, resp_valid, busy}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) slot(tbl[i].mask, tbl[i].g, tbl[i].gap, L + 1, tbl[i].data);
    req_valid = '0;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("bp_grant", {28'b0, req_ready}, 4'b1000);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {resp_valid, busy, resp_id, req_ready}, 8'b11110000);
      chk("bp_data", resp_data, stub(num[3], pos[3], op[3]));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {resp_valid, busy, 2'b0, req_ready}, 8'b00000001);
    req_valid = 4'b0100;
    #1;
    chk("rw_grant", {28'b0, req_ready}, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    chk("rw_in_wait", {31'b0, busy}, 1);
    rst = 1'b0;
    #1;
    chk("rw_reset", {resp_valid, busy, req_ready}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_no_resp", {30'b0, resp_valid, busy}, 0);
    end
    slot(4'b1101, 0, 0, L + 1, stub(num[0], pos[0], op[0]));
    num[2] = '0;
`ifdef FXFL_ZERO_BYPASS_EN
    slot(4'b0100, 2, 1, 1, 32'h0);
    chk("byp_conv_number", conv_number, 32'h32800000);
`else
    slot(4'b0100, 2, 1, L + 1, stub(32'h0, pos[2], op[2]));
    chk("zero_conv_number", conv_number, 32'h0);
`endif
    req_valid = '0;
    @(negedge clk);
    chk("final_idle", {30'b0, resp_valid, busy}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
